// File: rtl/distance_pkg.sv
// Shared constants and state encoding for the distance display front end.
package distance_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam int unsigned DEFAULT_RANGE_LIMIT = 100;
  localparam int unsigned DEFAULT_DIVISOR     = 10;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t DIVIDE = 2'd1;
  localparam state_t DONE   = 2'd2;

endpackage

// File: rtl/distance_digit_sequencer.sv
// Splits a raw distance sample into tens/units digits with a subtract-by-divisor
// loop, then applies leading-zero suppression and alarm blink blanking.
module distance_digit_sequencer
  import distance_pkg::*;
#(
  parameter int unsigned RANGE_LIMIT = DEFAULT_RANGE_LIMIT,
  parameter int unsigned DIVISOR     = DEFAULT_DIVISOR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [6:0] distance_raw,
  output logic       sample_ready,
  input  logic       alarm_active,
  input  logic       blink_tick,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_units,
  output logic       out_of_range,
  output logic       digits_valid,
  output logic       busy
);

  localparam logic [6:0] LIMIT_W   = 7'(RANGE_LIMIT);
  localparam logic [6:0] DIVISOR_W = 7'(DIVISOR);

  state_t     state;
  logic [6:0] remainder;
  logic [3:0] quotient;
  logic       blink_phase;
  logic       blanked;

  // Divider FSM; held results change only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      remainder    <= '0;
      quotient     <= '0;
      tens         <= '0;
      units        <= '0;
      out_of_range <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_valid) begin
            if (distance_raw < LIMIT_W) begin
              remainder <= distance_raw;
              quotient  <= '0;
              state     <= DIVIDE;
            end else begin
              tens         <= BLANK_CODE;
              units        <= BLANK_CODE;
              out_of_range <= 1'b1;
              state        <= DONE;
            end
          end
        end
        DIVIDE: begin
          if (remainder >= DIVISOR_W) begin
            remainder <= remainder - DIVISOR_W;
            quotient  <= quotient + 4'd1;
          end else begin
            tens         <= quotient;
            units        <= remainder[3:0];
            out_of_range <= 1'b0;
            state        <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Dropping the alarm clears the phase even if a tick arrives on the same edge.
  always_ff @(posedge clk) begin
    if (reset || !alarm_active) begin
      blink_phase <= 1'b0;
    end else if (blink_tick) begin
      blink_phase <= ~blink_phase;
    end
  end

  assign sample_ready = (state == IDLE);
  assign digits_valid = (state == DONE);
  assign busy         = (state == DIVIDE) || (state == DONE);
  assign blanked      = alarm_active && blink_phase;

  always_comb begin
    disp_tens  = tens;
    disp_units = units;
    if (blanked || out_of_range || (tens == 4'd0)) begin
      disp_tens = BLANK_CODE;
    end
    if (blanked || out_of_range) begin
      disp_units = BLANK_CODE;
    end
  end

endmodule

// File: tb/tb_distance_digit_sequencer.sv
// Scoreboard bench: accepted samples push expected digits and result edge;
// the monitor pops and compares whenever digits_valid is seen.
module tb_distance_digit_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic [6:0] distance_raw = '0;
  logic       sample_ready;
  logic       alarm_active = 1'b0;
  logic       blink_tick = 1'b0;
  logic [3:0] tens;
  logic [3:0] units;
  logic [3:0] disp_tens;
  logic [3:0] disp_units;
  logic       out_of_range;
  logic       digits_valid;
  logic       busy;

  typedef struct {
    int tens;
    int units;
    int oor;
    int resultEdge;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   nChecks = 0;
  int   nFails = 0;

  distance_digit_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .distance_raw (distance_raw),
    .sample_ready (sample_ready),
    .alarm_active (alarm_active),
    .blink_tick   (blink_tick),
    .tens         (tens),
    .units        (units),
    .disp_tens    (disp_tens),
    .disp_units   (disp_units),
    .out_of_range (out_of_range),
    .digits_valid (digits_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: digits from plain division, latency from the number of
  // subtraction steps needed.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && sample_valid && sample_ready) begin
      if (int'(distance_raw) >= 100) begin
        e.tens = 15; e.units = 15; e.oor = 1;
        e.resultEdge = cyc + 1;
      end else begin
        e.tens = int'(distance_raw) / 10;
        e.units = int'(distance_raw) % 10;
        e.oor = 0;
        e.resultEdge = cyc + 1 + int'(distance_raw) / 10 + 1;
      end
      sb.push_back(e);
    end
    if (digits_valid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_digits_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("tens", int'(tens), e.tens);
        checkOutput("units", int'(units), e.units);
        checkOutput("out_of_range", int'(out_of_range), e.oor);
        checkOutput("disp_tens", int'(disp_tens), (e.oor == 1 || e.tens == 0) ? 15 : e.tens);
        checkOutput("disp_units", int'(disp_units), e.oor == 1 ? 15 : e.units);
        checkOutput("latency_edge", cyc, e.resultEdge);
        checkOutput("busy_in_done", int'(busy), 1);
      end
    end
  end

  // Offers one sample and holds it until the handshake completes.
  task automatic applyStimulus(input int d);
    bit accepted = 0;
    sample_valid = 1'b1;
    distance_raw = 7'(d);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sample_ready) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) checkOutput("handshake_timeout", 0, 1);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_ready && sb.size() == 0) begin
        idle = 1;
        break;
      end
    end
    if (!idle) checkOutput("idle_timeout", 0, 1);
  endtask

  task automatic tickBlink();
    @(posedge clk);
    #1 blink_tick = 1'b1;
    @(posedge clk);
    #1 blink_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_tens", int'(tens), 0);
    checkOutput("reset_units", int'(units), 0);
    checkOutput("reset_ready", int'(sample_ready), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_valid", int'(digits_valid), 0);
    checkOutput("reset_disp_tens", int'(disp_tens), 15);
    checkOutput("reset_disp_units", int'(disp_units), 0);

    @(posedge clk);
    #1;
    applyStimulus(47);
    @(negedge clk);
    checkOutput("ready_low_after_accept", int'(sample_ready), 0);
    waitIdle();
    applyStimulus(5);
    waitIdle();
    applyStimulus(99);
    applyStimulus(100);
    waitIdle();

    // A sample offered mid-divide must be ignored.
    applyStimulus(72);
    @(posedge clk);
    #1;
    sample_valid = 1'b1;
    distance_raw = 7'd30;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    waitIdle();
    checkOutput("ignored_tens", int'(tens), 7);
    checkOutput("ignored_units", int'(units), 2);

    // Reset mid-divide: scoreboard flushed, any later pulse is spurious.
    applyStimulus(88);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_tens", int'(tens), 0);
    checkOutput("abort_units", int'(units), 0);
    checkOutput("abort_ready", int'(sample_ready), 1);
    repeat (12) @(posedge clk);
    #1;

    for (int n = 0; n < 24; n++) begin
      applyStimulus(int'($urandom_range(0, 127)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    applyStimulus(0);
    applyStimulus(9);
    applyStimulus(10);
    applyStimulus(127);
    waitIdle();

    // Blink blanking on a held 63.
    applyStimulus(63);
    waitIdle();
    alarm_active = 1'b1;
    #1;
    checkOutput("blink0_tens", int'(disp_tens), 6);
    checkOutput("blink0_units", int'(disp_units), 3);
    tickBlink();
    checkOutput("blink1_tens", int'(disp_tens), 15);
    checkOutput("blink1_units", int'(disp_units), 15);
    tickBlink();
    checkOutput("blink2_tens", int'(disp_tens), 6);
    checkOutput("blink2_units", int'(disp_units), 3);
    tickBlink();
    checkOutput("blink3_tens", int'(disp_tens), 15);
    alarm_active = 1'b0;
    #1;
    checkOutput("alarm_off_tens", int'(disp_tens), 6);
    checkOutput("alarm_off_units", int'(disp_units), 3);
    @(posedge clk);
    #1 alarm_active = 1'b1;
    #1;
    checkOutput("phase_cleared_tens", int'(disp_tens), 6);
    checkOutput("phase_cleared_units", int'(disp_units), 3);
    alarm_active = 1'b0;

    waitIdle();
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
